reqrsp_bank_responder: RTL and testbench
========================================

# reqrsp_bank_responder

Memory-side responder that terminates one output port of the cache/TCDM request crossbar. It accepts tagged requests, drives a fixed-latency single-port SRAM bank, and returns exactly one tagged response per request. The returned tag is the crossbar input index, so the response crossbar can route it back. A credit counter bounds outstanding requests so the response buffer can never overflow under response back-pressure.

## Interface
- NumInp, 32, crossbar input count; tag width is $clog2(NumInp) (min 1).
- AddrWidth, 10, SRAM word address width.
- DataWidth, 64, data width; strobe width is DataWidth/8.
- SramLatency, 1, cycles from SRAM request to read data valid; legal values are 1..3.
- NumOutstanding, 4, maximum requests in flight (pipeline plus buffer); must be ≥ SramLatency.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_addr_i  in  AddrWidth  word address.
- req_write_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  DataWidth  write data.
- req_strb_i  in  DataWidth/8  byte enables.
- req_src_i  in  $clog2(NumInp)  originating crossbar input index.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- rsp_data_o  out  DataWidth  read data; '0 for write acks and whenever not valid.
- rsp_dst_o  out  $clog2(NumInp)  echoed req_src_i; '0 when not valid.
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
- sram_req_o, sram_we_o  out  1  SRAM enable and write enable.
- sram_addr_o  out  AddrWidth  SRAM address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  DataWidth/8  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid SramLatency cycles after sram_req_o.

## Operation
- **Accept:** a request is accepted when `req_valid_i && req_ready_o`.
  - sram_req_o equals the accept condition, combinationally.
  - sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o pass through the request fields.
  - These four outputs are '0 when no request is accepted.
- **Credit counter:** width $clog2(NumOutstanding+1), reset value 0.
  - +1 on each accept that generates a response.
  - −1 on each response handshake.
  - Both in the same cycle: the count is unchanged.
  - `req_ready_o = (count < NumOutstanding)`. There is no same-cycle ready bypass from rsp_ready_i.
- **Tag pipeline:** SramLatency stages, each holding {valid, src, write}. It is advanced every cycle and never stalls, because the SRAM is fixed-latency.
- **Response buffer:** fall-through FIFO with depth NumOutstanding.
  - Each entry is {data, src}.
  - data = sram_rdata_i for reads, '0 for writes.
  - It is written when the last pipeline stage is valid.
  - The credit counter guarantees the FIFO is never full when it is written. An assertion flags any write into a full FIFO.
- **Ordering:** responses return strictly in acceptance order.
- **Muting:** rsp_data_o and rsp_dst_o are forced to '0 while rsp_valid_o = 0.

## Timing
- Reset values: req_ready_o = 1; rsp_valid_o = 0; all sram_* = 0; rsp_data_o = rsp_dst_o = 0.
- Latency: a request accepted in cycle t produces rsp_valid_o in cycle t+SramLatency when the FIFO is empty. Otherwise the response waits behind older entries.
- Throughput: one request and one response per cycle, sustained, while rsp_ready_i = 1.
- Full credits: req_ready_o drops the cycle after count reaches NumOutstanding. It rises the cycle after a response handshake frees a credit.
- Back-pressure: rsp_valid_o stays high and rsp_data_o / rsp_dst_o stay stable until the handshake.
- Reset mid-operation: the pipeline is cleared, the FIFO is emptied, count returns to 0, and in-flight responses are discarded.

## Configuration
- `REQRSP_BANK_WRITE_ACK_EN`
  - Defined: every write returns one response with rsp_data_o = '0; writes consume credits.
  - Undefined: writes are posted. They consume no credit, enter no pipeline stage and produce no response; only reads return responses.

## Structure
- Package reqrsp_bank_pkg holds:
  - the tag-stage typedef {valid, src, write};
  - the FIFO entry typedef {data, src};
  - the constant MaxSramLatency = 3.
- One sub-module: the common_cells fifo_v3 instance for the response buffer (FALL_THROUGH = 1, DEPTH = NumOutstanding).
- Credit counter and tag pipeline are inline.

## Test plan
- **Single read:** SramLatency = 2; read addr 0x10 with src = 5; SRAM model returns 0xDEAD_BEEF → rsp_valid_o at t+2 with data 0xDEAD_BEEF and dst 5.
- **Back-to-back reads:** 8 reads to addrs 0..7 with src = addr, rsp_ready_i held at 1 → 8 in-order responses on consecutive cycles, req_ready_o never low.
- **Credit exhaustion:** rsp_ready_i = 0; issue 6 reads with NumOutstanding = 4 → exactly 4 accepted and req_ready_o = 0. Then pulse rsp_ready_i once → req_ready_o returns to 1 in the next cycle and the 5th read is accepted.
- **Write ack:** write 0xFF to addr 3 with strb 0x01, then read addr 3.
  - With the macro: a write ack (data 0) is followed by a read response.
  - Without the macro: only the read response appears.
- **Simultaneous events:** count = NumOutstanding−1, with an accept and a response handshake in the same cycle → count unchanged and req_ready_o stays 1.
- **Reset mid-flight:** assert rst_i with 3 responses buffered → rsp_valid_o = 0 and req_ready_o = 1 immediately, and no stale responses appear after release.

Source files
------------

// File: rtl/reqrsp_bank_responder_pkg.sv
// Shared types for the bank responder: tag-pipeline stage and response-buffer entry.
// Bus widths are fixed here; the top checks its parameters against them.
package reqrsp_bank_pkg;

    localparam int unsigned MaxSramLatency = 3;
    localparam int unsigned BankNumInp     = 32;
    localparam int unsigned BankDataWidth  = 64;
    localparam int unsigned BankSrcWidth   = (BankNumInp > 1) ? $clog2(BankNumInp) : 1;

    typedef logic [BankSrcWidth-1:0]  src_t;
    typedef logic [BankDataWidth-1:0] data_t;

    typedef struct packed {
        logic valid;
        src_t src;
        logic write;
    } tag_stage_t;

    typedef struct packed {
        data_t data;
        src_t  src;
    } rsp_entry_t;

endpackage

// File: rtl/reqrsp_bank_responder_if.sv
// Request/response/SRAM bundle between the crossbar port, the responder and its SRAM bank.
interface reqrsp_bank_responder_if #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned SrcWidth  = 5
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [AddrWidth-1:0] req_addr;
    logic                 req_write;
    logic [DataWidth-1:0] req_wdata;
    logic [StrbWidth-1:0] req_strb;
    logic [SrcWidth-1:0]  req_src;
    logic                 req_valid;
    logic                 req_ready;

    logic [DataWidth-1:0] rsp_data;
    logic [SrcWidth-1:0]  rsp_dst;
    logic                 rsp_valid;
    logic                 rsp_ready;

    logic                 sram_req;
    logic                 sram_we;
    logic [AddrWidth-1:0] sram_addr;
    logic [DataWidth-1:0] sram_wdata;
    logic [StrbWidth-1:0] sram_be;
    logic [DataWidth-1:0] sram_rdata;

    // Master is the crossbar side plus the SRAM model; slave is the responder.
    modport master (
        output req_addr, req_write, req_wdata, req_strb, req_src, req_valid, rsp_ready,
        output sram_rdata,
        input  req_ready, rsp_data, rsp_dst, rsp_valid,
        input  sram_req, sram_we, sram_addr, sram_wdata, sram_be
    );

    modport slave (
        input  req_addr, req_write, req_wdata, req_strb, req_src, req_valid, rsp_ready,
        input  sram_rdata,
        output req_ready, rsp_data, rsp_dst, rsp_valid,
        output sram_req, sram_we, sram_addr, sram_wdata, sram_be
    );

endinterface

// File: rtl/reqrsp_bank_responder_fifo.sv
// Response buffer in the style of common_cells fifo_v3: optional fall-through, any depth.
module reqrsp_bank_responder_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 4,
    parameter type         dtype        = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    dtype mem_q [DEPTH];
    dtype mem_d [DEPTH];
    ptr_t rd_q, rd_d, wr_q, wr_d;
    cnt_t cnt_q, cnt_d;
    logic bypass, push_en, pop_en;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == cnt_t'(DEPTH));
    assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
    assign empty_o = (cnt_q == '0) && !bypass;
    assign data_o  = bypass ? data_i : mem_q[rd_q];
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        // A bypassed word popped in the same cycle never touches storage.
        if (!(bypass && pop_en)) begin
            if (push_en) begin
                mem_d[wr_q] = data_i;
                wr_d        = next_ptr(wr_q);
            end
            if (pop_en) begin
                rd_d = next_ptr(rd_q);
            end
            cnt_d = cnt_q + cnt_t'(push_en) - cnt_t'(pop_en);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reqrsp_bank_responder.sv
// Terminates one crossbar port on a fixed-latency SRAM bank, returning tagged responses in order.
// Define REQRSP_BANK_WRITE_ACK_EN to acknowledge writes; otherwise writes are posted.
module reqrsp_bank_responder
    import reqrsp_bank_pkg::*;
#(
    parameter int unsigned NumInp         = BankNumInp,
    parameter int unsigned AddrWidth      = 10,
    parameter int unsigned DataWidth      = BankDataWidth,
    parameter int unsigned SramLatency    = 1,
    parameter int unsigned NumOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    reqrsp_bank_responder_if.slave bus_io
);
    localparam int unsigned CntW = $clog2(NumOutstanding + 1);
    typedef logic [CntW-1:0] cnt_t;

    if (NumInp != BankNumInp || DataWidth != BankDataWidth) begin : g_bad_width
        $error("NumInp/DataWidth must match reqrsp_bank_pkg");
    end
    if (SramLatency < 1 || SramLatency > MaxSramLatency || NumOutstanding < SramLatency)
    begin : g_bad_latency
        $error("SramLatency must be 1..3 and not exceed NumOutstanding");
    end

    cnt_t                         credit_q, credit_d;
    tag_stage_t [SramLatency-1:0] stage_q, stage_d;
    rsp_entry_t                   push_entry, head_entry;
    logic accept, gen_rsp, rsp_hs, fifo_push, fifo_full, fifo_empty;

    assign bus_io.req_ready = (credit_q < cnt_t'(NumOutstanding));
    // Reset gating keeps the SRAM port quiet while rst_i is held.
    assign accept = bus_io.req_valid & bus_io.req_ready & ~rst_i;
`ifdef REQRSP_BANK_WRITE_ACK_EN
    assign gen_rsp = accept;
`else
    assign gen_rsp = accept & ~bus_io.req_write;
`endif
    assign rsp_hs = bus_io.rsp_valid & bus_io.rsp_ready;

    always_comb begin
        bus_io.sram_req   = accept;
        bus_io.sram_we    = accept & bus_io.req_write;
        bus_io.sram_addr  = accept ? bus_io.req_addr : AddrWidth'(0);
        bus_io.sram_wdata = accept ? bus_io.req_wdata : DataWidth'(0);
        bus_io.sram_be    = accept ? bus_io.req_strb : '0;
    end

    always_comb begin
        credit_d = credit_q;
        unique case ({gen_rsp, rsp_hs})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_comb begin
        stage_d[0] = '{valid: gen_rsp, src: bus_io.req_src, write: bus_io.req_write};
        for (int i = 1; i < SramLatency; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit_q <= '0;
            stage_q  <= '0;
        end else begin
            credit_q <= credit_d;
            stage_q  <= stage_d;
        end
    end

    assign fifo_push       = stage_q[SramLatency-1].valid;
    assign push_entry.data = stage_q[SramLatency-1].write ? DataWidth'(0) : bus_io.sram_rdata;
    assign push_entry.src  = stage_q[SramLatency-1].src;

    reqrsp_bank_responder_fifo #(
        .FALL_THROUGH (1'b1),
        .DEPTH        (NumOutstanding),
        .dtype        (rsp_entry_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (push_entry),
        .push_i  (fifo_push),
        .data_o  (head_entry),
        .pop_i   (rsp_hs)
    );

    always_comb begin
        bus_io.rsp_valid = ~fifo_empty;
        bus_io.rsp_data  = fifo_empty ? DataWidth'(0) : head_entry.data;
        bus_io.rsp_dst   = fifo_empty ? '0 : head_entry.src;
    end

    // Credits bound occupancy, so a push into a full buffer is a design bug.
    assert property (@(posedge clk_i) disable iff (rst_i) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_reqrsp_bank_responder.sv
// Directed bench for reqrsp_bank_responder with SramLatency = 2 and NumOutstanding = 4.
module tb_reqrsp_bank_responder;
    localparam int unsigned AddrWidth      = 10;
    localparam int unsigned DataWidth      = 64;
    localparam int unsigned NumInp         = 32;
    localparam int unsigned SrcWidth       = 5;
    localparam int unsigned SramLatency    = 2;
    localparam int unsigned NumOutstanding = 4;
    localparam logic [63:0] Fill           = 64'hA5A5_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned accepted;

    logic [63:0] mem [1024];
    logic [63:0] rd0, rd1;

    reqrsp_bank_responder_if #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .SrcWidth  (SrcWidth)
    ) bus ();

    reqrsp_bank_responder #(
        .NumInp         (NumInp),
        .AddrWidth      (AddrWidth),
        .DataWidth      (DataWidth),
        .SramLatency    (SramLatency),
        .NumOutstanding (NumOutstanding)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: two-cycle read latency, byte-enabled writes, contents reloaded in reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= Fill | 64'(i);
            mem[16] <= 64'hDEAD_BEEF;
        end else if (bus.sram_req && bus.sram_we) begin
            for (int b = 0; b < 8; b++)
                if (bus.sram_be[b]) mem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
        end
        rd0 <= mem[bus.sram_addr];
        rd1 <= rd0;
    end
    assign bus.sram_rdata = rd1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic v, input logic w, input logic [9:0] a,
                         input logic [63:0] d, input logic [7:0] s, input logic [4:0] src);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_strb  = s;
        bus.req_src   = src;
    endtask

    task automatic rd(input logic [9:0] a, input logic [4:0] src);
        drive(1'b1, 1'b0, a, 64'h0, 8'h00, src);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 10'h0, 64'h0, 8'h00, 5'h0);
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, "_valid"}, 64'(bus.rsp_valid), 64'd0);
        check_eq({tag, "_data"}, bus.rsp_data, 64'd0);
        check_eq({tag, "_dst"}, 64'(bus.rsp_dst), 64'd0);
    endtask

    initial begin
        // Reset: a pending request must not reach the SRAM.
        rd(10'h5, 5'd1);
        bus.rsp_ready = 1'b1;
        #2;
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("rst_sram_req", 64'(bus.sram_req), 64'd0);
        check_eq("rst_sram_addr", 64'(bus.sram_addr), 64'd0);
        check_empty("rst_rsp");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        step();

        // Single read, two-cycle latency.
        rd(10'h10, 5'd5);
        settle();
        check_eq("single_sram_req", 64'(bus.sram_req), 64'd1);
        check_eq("single_sram_addr", 64'(bus.sram_addr), 64'h10);
        check_eq("single_sram_we", 64'(bus.sram_we), 64'd0);
        step();
        idle();
        settle();
        check_empty("single_t1");
        check_eq("single_idle_sram_addr", 64'(bus.sram_addr), 64'd0);
        step();
        settle();
        check_eq("single_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("single_data", bus.rsp_data, 64'hDEAD_BEEF);
        check_eq("single_dst", 64'(bus.rsp_dst), 64'd5);
        step();
        settle();
        check_empty("single_after");
        step();

        // Back-to-back reads, full throughput.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) rd(10'(k), 5'(k));
            else idle();
            settle();
            if (k < 8) check_eq("b2b_req_ready", 64'(bus.req_ready), 64'd1);
            if (k >= 2) begin
                check_eq("b2b_valid", 64'(bus.rsp_valid), 64'd1);
                check_eq("b2b_dst", 64'(bus.rsp_dst), 64'(k - 2));
                check_eq("b2b_data", bus.rsp_data, Fill | 64'(k - 2));
            end else begin
                check_eq("b2b_head_valid", 64'(bus.rsp_valid), 64'd0);
            end
            step();
        end
        settle();
        check_empty("b2b_after");
        step();

        // Credit exhaustion under back-pressure.
        bus.rsp_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            rd(10'(accepted), 5'(10 + accepted));
            settle();
            if (bus.req_ready) accepted++;
            step();
        end
        settle();
        check_eq("credit_accepted", 64'(accepted), 64'd4);
        check_eq("credit_ready_low", 64'(bus.req_ready), 64'd0);
        check_eq("credit_head_dst", 64'(bus.rsp_dst), 64'd10);
        check_eq("credit_head_data", bus.rsp_data, Fill);
        bus.rsp_ready = 1'b1;
        #1;
        check_eq("credit_stable_dst", 64'(bus.rsp_dst), 64'd10);
        step();
        bus.rsp_ready = 1'b0;
        settle();
        check_eq("credit_ready_back", 64'(bus.req_ready), 64'd1);
        check_eq("credit_fifth_sram_req", 64'(bus.sram_req), 64'd1);
        check_eq("credit_fifth_addr", 64'(bus.sram_addr), 64'd4);
        check_eq("credit_next_dst", 64'(bus.rsp_dst), 64'd11);
        step();
        idle();
        settle();
        check_eq("credit_ready_full_again", 64'(bus.req_ready), 64'd0);
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) settle();
            check_eq("credit_drain_valid", 64'(bus.rsp_valid), 64'd1);
            check_eq("credit_drain_dst", 64'(bus.rsp_dst), 64'(11 + j));
            check_eq("credit_drain_data", bus.rsp_data, Fill | 64'(1 + j));
            step();
        end
        settle();
        check_empty("credit_after");
        step();

        // Accept and response handshake in the same cycle at count = NumOutstanding - 1.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(10'(i), 5'(20 + i));
            settle();
            check_eq("simul_fill_ready", 64'(bus.req_ready), 64'd1);
            step();
        end
        idle();
        step();
        step();
        rd(10'h3, 5'd23);
        bus.rsp_ready = 1'b1;
        settle();
        check_eq("simul_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("simul_dst", 64'(bus.rsp_dst), 64'd20);
        check_eq("simul_ready", 64'(bus.req_ready), 64'd1);
        step();
        rd(10'h4, 5'd24);
        bus.rsp_ready = 1'b0;
        settle();
        check_eq("simul_ready_unchanged", 64'(bus.req_ready), 64'd1);
        step();
        idle();
        settle();
        check_eq("simul_ready_now_full", 64'(bus.req_ready), 64'd0);
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) settle();
            check_eq("simul_drain_dst", 64'(bus.rsp_dst), 64'(21 + j));
            check_eq("simul_drain_data", bus.rsp_data, Fill | 64'(1 + j));
            step();
        end
        settle();
        check_empty("simul_after");
        step();

        // Write followed by a read of the same word.
        drive(1'b1, 1'b1, 10'h3, 64'hFF, 8'h01, 5'd7);
        settle();
        check_eq("wr_sram_we", 64'(bus.sram_we), 64'd1);
        check_eq("wr_sram_be", 64'(bus.sram_be), 64'h01);
        check_eq("wr_sram_wdata", bus.sram_wdata, 64'hFF);
        step();
        rd(10'h3, 5'd8);
        settle();
        check_eq("wr_read_ready", 64'(bus.req_ready), 64'd1);
        step();
        idle();
        settle();
`ifdef REQRSP_BANK_WRITE_ACK_EN
        check_eq("wr_ack_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("wr_ack_dst", 64'(bus.rsp_dst), 64'd7);
        check_eq("wr_ack_data", bus.rsp_data, 64'd0);
`else
        check_empty("wr_posted");
`endif
        step();
        settle();
        check_eq("wr_rd_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("wr_rd_dst", 64'(bus.rsp_dst), 64'd8);
        check_eq("wr_rd_data", bus.rsp_data, Fill | 64'hFF);
        step();
        settle();
        check_empty("wr_after");
        step();

        // Reset with three responses buffered.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(10'(i), 5'(1 + i));
            step();
        end
        idle();
        step();
        step();
        settle();
        check_eq("mid_buffered", 64'(bus.rsp_valid), 64'd1);
        check_eq("mid_buffered_dst", 64'(bus.rsp_dst), 64'd1);
        rst = 1'b1;
        #1;
        check_empty("mid_rst");
        check_eq("mid_rst_ready", 64'(bus.req_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            settle();
            check_eq("mid_no_stale", 64'(bus.rsp_valid), 64'd0);
            step();
        end
        rd(10'h0, 5'd9);
        step();
        idle();
        settle();
        check_eq("mid_fresh_early", 64'(bus.rsp_valid), 64'd0);
        step();
        settle();
        check_eq("mid_fresh_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("mid_fresh_dst", 64'(bus.rsp_dst), 64'd9);
        check_eq("mid_fresh_data", bus.rsp_data, Fill);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
